// File: rtl/pulse_timing_gen.sv
// Radar pulse-repetition timing generator: sequences TX, guard (blanking) and RX windows
// over a burst of pulses, stepping once per rising edge of the divided tick input.
module pulse_timing_gen #(
  parameter int unsigned TX_TICKS    = 8,
  parameter int unsigned GUARD_TICKS = 2,
  parameter int unsigned RX_TICKS    = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] num_pulses,
  output logic        tx_gate,
  output logic        blank,
  output logic        rx_gate,
  output logic        sample_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] pulse_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_TX    = 3'd2,
    ST_GUARD = 3'd3,
    ST_RX    = 3'd4
  } state_e;

  localparam logic [15:0] TX_LAST    = 16'(TX_TICKS - 32'd1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_TICKS - 32'd1);
  localparam logic [15:0] RX_LAST    = 16'(RX_TICKS - 32'd1);

  state_e      state_q, state_d;
  logic        tick_q;
  logic [15:0] phase_q, phase_d;
  logic [15:0] pulse_cnt_q, pulse_cnt_d;
  logic [15:0] num_q, num_d;
  logic        tx_gate_q, tx_gate_d;
  logic        blank_q, blank_d;
  logic        rx_gate_q, rx_gate_d;
  logic        sample_en_q, sample_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick_s;
  logic [15:0] pulse_inc_s;

  assign tick_s      = tick_in & ~tick_q;
  assign pulse_inc_s = pulse_cnt_q + 16'd1;

  // Next-state, counter and output decode; stop outranks any tick outside IDLE
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pulse_cnt_d = pulse_cnt_q;
    num_d       = num_q;
    sample_en_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d     = ST_ARM;
          num_d       = num_pulses;
          pulse_cnt_d = 16'd0;
          phase_d     = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (stop) begin
          state_d = ST_IDLE;
          phase_d = 16'd0;
        end else if (tick_s) begin
          state_d = ST_TX;
          phase_d = 16'd0;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_TX: begin
        if (stop) begin
          state_d = ST_IDLE;
          phase_d = 16'd0;
        end else if (tick_s) begin
          if (phase_q == TX_LAST) begin
            state_d = ST_GUARD;
            phase_d = 16'd0;
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end else begin
          state_d = ST_TX;
        end
      end
      ST_GUARD: begin
        if (stop) begin
          state_d = ST_IDLE;
          phase_d = 16'd0;
        end else if (tick_s) begin
          if (phase_q == GUARD_LAST) begin
            state_d = ST_RX;
            phase_d = 16'd0;
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end else begin
          state_d = ST_GUARD;
        end
      end
      ST_RX: begin
        if (stop) begin
          state_d = ST_IDLE;
          phase_d = 16'd0;
        end else if (tick_s) begin
          sample_en_d = 1'b1;
          if (phase_q == RX_LAST) begin
            phase_d     = 16'd0;
            pulse_cnt_d = pulse_inc_s;
            // A zero burst length means run until stopped
            if ((num_q != 16'd0) && (pulse_inc_s == num_q)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_TX;
            end
          end else begin
            phase_d = phase_q + 16'd1;
          end
        end else begin
          state_d = ST_RX;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 16'd0;
      end
    endcase
    tx_gate_d = (state_d == ST_TX);
    blank_d   = (state_d == ST_TX) || (state_d == ST_GUARD);
    rx_gate_d = (state_d == ST_RX);
    busy_d    = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= 1'b0;
      phase_q     <= 16'd0;
      pulse_cnt_q <= 16'd0;
      num_q       <= 16'd0;
      tx_gate_q   <= 1'b0;
      blank_q     <= 1'b0;
      rx_gate_q   <= 1'b0;
      sample_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_in;
      phase_q     <= phase_d;
      pulse_cnt_q <= pulse_cnt_d;
      num_q       <= num_d;
      tx_gate_q   <= tx_gate_d;
      blank_q     <= blank_d;
      rx_gate_q   <= rx_gate_d;
      sample_en_q <= sample_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_gate   = tx_gate_q;
  assign blank     = blank_q;
  assign rx_gate   = rx_gate_q;
  assign sample_en = sample_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule
